load_store_unit: RTL

//  Sits between the core's execute stage and the word-wide data memory.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute stage to a word-wide data memory for RV32I loads and stores.
//   Loads extract the addressed byte/half lane and sign- or zero-extend it.
//   Sub-word stores read the containing word, merge the new lane, then write it back.
//   Word stores are issued as a single write.
//   The unit handles one request at a time and signals completion with a one-cycle resp_valid.
//
// Configuration macro: MISALIGN_TRAP_EN
//   Defined:   a misaligned H/HU/W access returns at once with resp_misaligned=1 and no memory
//              access.
//   Undefined: the address is aligned down and the access completes normally.
//              resp_misaligned is always 0.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   req_*             request handshake (valid/ready), funct3, byte address, store data
//   resp_*            completion pulse, extended load data, misalignment flag
//   mem_*             word-addressed memory: write strobe, word index, write data, read data
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_t;

    localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(READ_LATENCY - 1);

    // Illegal encodings (011, 11x, and stores with 10x) fall through to word width.
    function automatic size_t dec_size(input logic write, input logic [2:0] f3);
        if (f3 == 3'b000 || (!write && f3 == 3'b100)) begin
            return SzByte;
        end else if (f3 == 3'b001 || (!write && f3 == 3'b101)) begin
            return SzHalf;
        end else begin
            return SzWord;
        end
    endfunction

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            write_q, write_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic [31:0]     wword_q, wword_d;

    size_t       req_size, size_q;
    logic        req_mis;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data, merged;

    assign req_size = dec_size(req_write, req_funct3);
    assign size_q   = dec_size(write_q, funct3_q);

`ifdef MISALIGN_TRAP_EN
    assign req_mis = (req_size == SzHalf && req_addr[0]) ||
                     (req_size == SzWord && req_addr[1:0] != 2'b00);
`else
    // Never set, so mis_q stays 0 and the flag is constant.
    assign req_mis = 1'b0;
`endif

    // Lane extract / insert; low address bits beyond the access width are ignored,
    // which is what aligns a misaligned access down when trapping is off.
    always_comb begin
        lane_byte = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        lane_half = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_data_out;
        merged    = mem_data_out;
        unique case (size_q)
            SzByte: begin
                load_data = funct3_q[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SzHalf: begin
                load_data = funct3_q[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        wword_d  = wword_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata[15:0];
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    rdata_d  = 32'h0;
                    mis_d    = 1'b0;
                    cnt_d    = CntInit;
                    if (req_mis) begin
                        mis_d   = 1'b1;
                        state_d = StResp;
                    end else if (req_write && req_size == SzWord) begin
                        wword_d = req_wdata;
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (write_q) begin
                    wword_d = merged;
                    state_d = StWr;
                end else begin
                    rdata_d = load_data;
                    state_d = StResp;
                end
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 16'h0;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
            wword_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            wword_q  <= wword_d;
        end
    end

    assign req_ready        = (state_q == StIdle);
    assign resp_valid       = (state_q == StResp);
    assign resp_rdata       = rdata_q;
    assign resp_misaligned  = mis_q;
    assign mem_write_enable = (state_q == StWr);
    assign mem_address      = {2'b00, addr_q[31:2]};
    assign mem_data_in      = wword_q;

endmodule
